// File: rtl/bcd_table_sequencer.sv
// Plays (value, duration) entries stored as BCD digits in an external nibble-wide EPROM.
// Digits are fetched one per read, converted to binary, and VALUE is held on out for DURATION clocks.
module bcd_table_sequencer #(
    parameter int            AW     = 8,
    parameter int            DIGITS = 2,
    parameter int            OW     = 7,
    parameter int            WS     = 0,
    parameter logic [AW-1:0] BASE   = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_mode,
    input  logic [3:0]    data,
    output logic [AW-1:0] addr,
    output logic          mr_,
    output logic          s_,
    output logic [OW-1:0] out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state
);

    localparam int ND = 2 * DIGITS;
    localparam int IW = $clog2(ND);
    localparam int WW = (WS > 0) ? $clog2(WS + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, CHECK, PLAY} state_t;

    state_t        state, state_nx;
    logic [3:0]    dig [ND];
    logic [IW-1:0] idx;
    logic [WW-1:0] wcnt;
    logic [OW-1:0] cnt;
    logic          loop_r;

    logic          sample, run_start, play_load, err_set, rewind, done_nx;
    logic          bad;
    int            val_acc, dur_acc, scale;
    logic [OW-1:0] value_bin, dur_bin;

    // Digits are stored least significant first: VALUE in [0..DIGITS-1], DURATION above it.
    always_comb begin
        val_acc = 0;
        dur_acc = 0;
        scale   = 1;
        bad     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            val_acc = val_acc + int'(dig[i]) * scale;
            dur_acc = dur_acc + int'(dig[DIGITS+i]) * scale;
            scale   = scale * 10;
        end
        for (int i = 0; i < ND; i++) begin
            if (dig[i] > 4'd9) bad = 1'b1;
        end
        value_bin = OW'(val_acc);
        dur_bin   = OW'(dur_acc);
    end

    always_comb begin
        state_nx  = state;
        sample    = 1'b0;
        run_start = 1'b0;
        play_load = 1'b0;
        err_set   = 1'b0;
        rewind    = 1'b0;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    run_start = 1'b1;
                    state_nx  = FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (wcnt == WW'(WS)) begin
                    sample = 1'b1;
                    if (idx == IW'(ND - 1)) state_nx = CHECK;
                end
            end
            CHECK: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (bad) begin
                    err_set  = 1'b1;
                    state_nx = FETCH;
                end else if (dur_bin == '0) begin
                    if (loop_r) begin
                        rewind   = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    play_load = 1'b1;
                    state_nx  = PLAY;
                end
            end
            PLAY: begin
                if (stop) state_nx = IDLE;
                else if (cnt == OW'(1)) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= BASE;
            out    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            loop_r <= 1'b0;
            idx    <= '0;
            wcnt   <= '0;
            cnt    <= '0;
            for (int i = 0; i < ND; i++) dig[i] <= '0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (run_start) begin
                loop_r <= loop_mode;
                err    <= 1'b0;
                addr   <= BASE;
                idx    <= '0;
                wcnt   <= '0;
            end
            if (state == FETCH && !stop && !sample) wcnt <= wcnt + WW'(1);
            if (sample) begin
                dig[idx] <= data;
                addr     <= addr + AW'(1);
                idx      <= (idx == IW'(ND - 1)) ? '0 : idx + IW'(1);
                wcnt     <= '0;
            end
            if (err_set) err <= 1'b1;
            if (rewind) addr <= BASE;
            if (play_load) begin
                out <= value_bin;
                cnt <= dur_bin;
            end
            if (state == PLAY) cnt <= cnt - OW'(1);
        end
    end

    assign mr_       = (state != FETCH);
    assign s_        = (state != FETCH);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bcd_table_sequencer.sv
// Bench for bcd_table_sequencer: directed tables plus random tables, compared cycle by cycle
// against a trace built from the table-walking rules (WS=2, BASE=FE so every table straddles the wrap).
module tb_bcd_table_sequencer;

    localparam int         AW     = 8;
    localparam int         DIGITS = 2;
    localparam int         OW     = 7;
    localparam int         WS     = 2;
    localparam logic [7:0] BASE   = 8'hFE;

    logic          clock = 1'b0;
    logic          reset, start, stop, loop_mode;
    logic [3:0]    data;
    logic [AW-1:0] addr;
    logic          mr_, s_;
    logic [OW-1:0] out;
    logic          busy, done, err;
    logic [1:0]    dbg_state;

    logic [3:0] mem [256];
    assign data = mem[addr];

    bcd_table_sequencer #(
        .AW(AW), .DIGITS(DIGITS), .OW(OW), .WS(WS), .BASE(BASE)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .loop_mode(loop_mode),
        .data(data), .addr(addr), .mr_(mr_), .s_(s_), .out(out), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] addr;
        logic       mr;
        logic [6:0] out;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_exp;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] model_out;
    logic [7:0] wp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void push_exp(logic [7:0] a, logic m, logic [6:0] o, logic b, logic d, logic e);
        exp_t x;
        x.addr = a; x.mr = m; x.out = o; x.busy = b; x.done = d; x.err = e;
        exp_q.push_back(x);
    endfunction

    // Walks the table the way the player is meant to, emitting one expected sample per clock.
    function automatic void build_model(logic lp, int limit);
        logic [7:0] a;
        logic [6:0] cur;
        logic       e;
        int         dg [4];
        int         val, dur;
        bit         bad, fin;
        exp_q.delete();
        a = BASE; cur = model_out; e = 1'b0; fin = 1'b0;
        while (!fin && exp_q.size() < limit) begin
            for (int i = 0; i < 2 * DIGITS; i++) begin
                for (int w = 0; w <= WS; w++) push_exp(a, 1'b0, cur, 1'b1, 1'b0, e);
                dg[i] = int'(mem[a]);
                a = a + 8'd1;
            end
            push_exp(a, 1'b1, cur, 1'b1, 1'b0, e);
            bad = 1'b0;
            for (int i = 0; i < 4; i++) if (dg[i] > 9) bad = 1'b1;
            val = dg[0] + 10 * dg[1];
            dur = dg[2] + 10 * dg[3];
            if (bad) begin
                e = 1'b1;
            end else if (dur == 0) begin
                if (lp) a = BASE;
                else begin
                    push_exp(a, 1'b1, cur, 1'b0, 1'b1, e);
                    fin = 1'b1;
                end
            end else begin
                cur = 7'(val);
                for (int k = 0; k < dur; k++) push_exp(a, 1'b1, cur, 1'b1, 1'b0, e);
            end
        end
        while (exp_q.size() > limit) void'(exp_q.pop_back());
    endfunction

    task automatic put(input int d);
        mem[wp] = 4'(d);
        wp = wp + 8'd1;
    endtask

    task automatic put_entry(input int val, input int dur);
        put(val % 10); put((val / 10) % 10); put(dur % 10); put((dur / 10) % 10);
    endtask

    // Starts a run, compares every clock against the model; a truncated trace ends with stop.
    task automatic run_table(input logic lp, input int limit);
        bit ended;
        build_model(lp, limit);
        ended = exp_q[$].done;
        @(negedge clock);
        start = 1'b1; stop = 1'b0; loop_mode = lp;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            last_exp = exp_q.pop_front();
            check("addr", addr, last_exp.addr);
            check("mr_", mr_, last_exp.mr);
            check("s_", s_, last_exp.mr);
            check("out", out, last_exp.out);
            check("busy", busy, last_exp.busy);
            check("done", done, last_exp.done);
            check("err", err, last_exp.err);
            if (exp_q.size() == 0) start = 1'b0;
            else start = 1'($urandom_range(0, 1));
            loop_mode = 1'($urandom_range(0, 1));
        end
        if (!ended) begin
            stop = 1'b1;
            @(negedge clock);
            check("stop_busy", busy, 1'b0);
            check("stop_mr_", mr_, 1'b1);
            check("stop_s_", s_, 1'b1);
            check("stop_done", done, 1'b0);
            check("stop_out", out, last_exp.out);
            check("stop_err", err, last_exp.err);
            stop = 1'b0;
        end else begin
            @(negedge clock);
            check("done_once", done, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_mr_", mr_, 1'b1);
        end
        model_out = last_exp.out;
    endtask

    task automatic load_t1();
        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        wp = BASE;
        put_entry(42, 3);
        put_entry(0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        model_out = '0;
        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        repeat (2) @(negedge clock);
        check("rst_addr", addr, BASE);
        check("rst_mr_", mr_, 1'b1);
        check("rst_s_", s_, 1'b1);
        check("rst_out", out, 7'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;

        // One-shot 42 for 3 clocks across the FF->00 wrap.
        load_t1();
        run_table(1'b0, 400);

        // Invalid digit entry is skipped, out stays 42, err set, done still pulses.
        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        wp = BASE;
        put_entry(42, 3);
        put(10); put(1); put(2); put(0);
        put_entry(0, 0);
        run_table(1'b0, 400);

        // Looping table 5,5,17 aborted by stop.
        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        wp = BASE;
        put_entry(5, 2);
        put_entry(17, 1);
        put_entry(0, 0);
        run_table(1'b1, 90);

        // Stop in the middle of a fetch keeps out.
        load_t1();
        run_table(1'b0, 4);

        // start and stop together in IDLE: stop wins.
        @(negedge clock);
        start = 1'b1; stop = 1'b1;
        @(negedge clock);
        check("ss_busy", busy, 1'b0);
        check("ss_mr_", mr_, 1'b1);
        start = 1'b0; stop = 1'b0;

        // Random tables, random mode.
        for (int t = 0; t < 8; t++) begin
            logic       lp;
            logic [7:0] p;
            int         nent;
            for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
            wp = BASE;
            nent = $urandom_range(1, 4);
            for (int n = 0; n < nent; n++) begin
                put_entry($urandom_range(0, 99), $urandom_range(1, 4));
                if ($urandom_range(0, 4) == 0) begin
                    p = wp - 8'(1 + $urandom_range(0, 3));
                    mem[p] = 4'($urandom_range(10, 15));
                end
            end
            put_entry($urandom_range(0, 99), 0);
            lp = 1'($urandom_range(0, 1));
            run_table(lp, lp ? $urandom_range(20, 150) : 400);
        end

        // Asynchronous reset during PLAY of 42.
        load_t1();
        @(negedge clock);
        start = 1'b1; loop_mode = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (13) @(negedge clock);
        check("play_out", out, 7'd42);
        check("play_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_out", out, 7'd0);
        check("arst_mr_", mr_, 1'b1);
        check("arst_s_", s_, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_addr", addr, BASE);
        check("arst_err", err, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        model_out = '0;
        run_table(1'b0, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
